// File: rtl/bme_spi_responder.sv
// bme_spi_responder: SPI mode-0 responder that emulates the BME280 register
// protocol. It has a 128x8 register file that the host preloads and the SPI
// master reads and writes. Each SPI data write is also reported to the host
// as a one-clk strobe.
module bme_spi_responder #(
    parameter logic [6:0] ID_ADDR     = 7'h50,
    parameter logic [7:0] ID_VALUE    = 8'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       load_en,
    input  logic [6:0] load_addr,
    input  logic [7:0] load_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RD   = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic       r_sck_d;
    logic       r_csn_d;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift_in;
    logic [7:0] r_shift_out;
    logic [6:0] r_addr;
    logic       r_miso;
    logic       r_busy;
    logic       r_wr_valid;
    logic [6:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_regs [0:127];

    logic       w_sck;
    logic       w_csn;
    logic       w_mosi;
    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_csn_fall;
    logic       w_csn_rise;
    logic       w_byte_done;
    logic [7:0] w_byte;
    logic       w_wr_fire;
    logic       w_spi_we;
    logic       w_rd_load;
    logic       w_rd_shift;
    logic [7:0] w_rd_val;
    logic       w_miso_nxt;

    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_csn       = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck & ~r_sck_d;
    assign w_sck_fall  = ~w_sck & r_sck_d;
    assign w_csn_fall  = ~w_csn & r_csn_d;
    assign w_csn_rise  = w_csn & ~r_csn_d;
    assign w_byte      = {r_shift_in[6:0], w_mosi};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7) && (r_state != S_IDLE);

    // Synchronise the SPI pins into clk and keep a one-clk history for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck_sync  <= {SYNC_STAGES{1'b0}};
            r_csn_sync  <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sck_d     <= 1'b0;
            r_csn_d     <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_d     <= w_sck;
            r_csn_d     <= w_csn;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: a chip-select release always aborts back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_csn_fall) w_state_nxt = S_CMD;
                else            w_state_nxt = S_IDLE;
            end
            S_CMD: begin
                if (w_csn_rise)       w_state_nxt = S_IDLE;
                else if (w_byte_done) w_state_nxt = w_byte[7] ? S_RD : S_WR;
                else                  w_state_nxt = S_CMD;
            end
            S_RD: begin
                if (w_csn_rise) w_state_nxt = S_IDLE;
                else            w_state_nxt = S_RD;
            end
            S_WR: begin
                if (w_csn_rise)       w_state_nxt = S_IDLE;
                else if (w_byte_done) w_state_nxt = S_CMD;
                else                  w_state_nxt = S_WR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: write strobe, read load/shift, and the next MISO level
    always_comb begin
        w_wr_fire  = (r_state == S_WR) && w_byte_done && !w_csn_rise;
        w_spi_we   = w_wr_fire && (r_addr != ID_ADDR);
        w_rd_load  = (r_state == S_RD) && w_sck_fall && (r_bit_cnt == 3'd0) && !w_csn_rise;
        w_rd_shift = (r_state == S_RD) && w_sck_fall && (r_bit_cnt != 3'd0) && !w_csn_rise;
        w_rd_val   = (r_addr == ID_ADDR) ? ID_VALUE : r_regs[r_addr];
        if (w_state_nxt != S_RD) begin
            w_miso_nxt = 1'b0;
        end else if (w_rd_load) begin
            w_miso_nxt = w_rd_val[7];
        end else if (w_rd_shift) begin
            w_miso_nxt = r_shift_out[6];
        end else begin
            w_miso_nxt = r_miso;
        end
    end

    // Bit/byte datapath, read address pointer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 8'h00;
            r_shift_out <= 8'h00;
            r_addr      <= 7'h00;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= 7'h00;
            r_wr_data   <= 8'h00;
        end else begin
            r_busy     <= ~w_csn;
            r_miso     <= w_miso_nxt;
            r_wr_valid <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_byte;
            end
            // The counter is held at zero between frames so a new frame starts aligned
            if (r_state == S_IDLE) begin
                r_bit_cnt  <= 3'd0;
                r_shift_in <= 8'h00;
            end else if (w_sck_rise) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_shift_in <= w_byte;
            end
            // The pointer advances once per loaded read byte and wraps mod 128
            if ((r_state == S_CMD) && w_byte_done) begin
                r_addr <= w_byte[6:0];
            end else if (w_rd_load) begin
                r_addr <= r_addr + 7'd1;
            end
            if (w_rd_load) begin
                r_shift_out <= w_rd_val;
            end else if (w_rd_shift) begin
                r_shift_out <= {r_shift_out[6:0], 1'b0};
            end
        end
    end

    // Register file: an SPI write takes priority over a host load to the same address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 128; i++) begin
                if (w_spi_we && (r_addr == 7'(i))) begin
                    r_regs[i] <= w_byte;
                end else if (load_en && (load_addr == 7'(i))) begin
                    r_regs[i] <= load_data;
                end
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_busy;
    assign busy        = r_busy;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;

endmodule

// File: tb/tb_bme_spi_responder.sv
// Directed testbench for bme_spi_responder. It acts as the SPI mode-0 master
// and the host loader, and records every wr_valid strobe.
module tb_bme_spi_responder;

    localparam int HALF = 8;   // clk cycles per SCK half period
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sck;
    logic       spi_csn;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       load_en;
    logic [6:0] load_addr;
    logic [7:0] load_data;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    logic [6:0] wr_a [0:15];
    logic [7:0] wr_d [0:15];
    logic [7:0] rx;
    int w0;

    bme_spi_responder #(.ID_ADDR(7'h50), .ID_VALUE(8'h60), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Log each wr_valid strobe on the inactive edge
    always @(negedge clk) begin
        if (wr_valid && (wr_cnt < 16)) begin
            wr_a[wr_cnt] <= wr_addr;
            wr_d[wr_cnt] <= wr_data;
            wr_cnt       <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        spi_csn = 1'b1;
        tick(HALF);
    endtask

    task automatic host_load(input logic [6:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick(1);
        load_en   = 1'b0;
        tick(1);
    endtask

    // Shift nbits MSB-first. With collide set, a host load is placed in the
    // same clk in which the responder acts on the 8th rising edge.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit collide,
                            input logic [6:0] ca, input logic [7:0] cd,
                            output logic [7:0] rxo);
        rxo = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            tick(HALF);
            rxo = {rxo[6:0], spi_miso};
            spi_sck = 1'b1;
            if (collide && (i == 7)) begin
                tick(SYNC);
                load_en   = 1'b1;
                load_addr = ca;
                load_data = cd;
                tick(1);
                load_en   = 1'b0;
                tick(HALF - SYNC - 1);
            end else begin
                tick(HALF);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx, output logic [7:0] rxo);
        spi_xfer(tx, 8, 1'b0, 7'h00, 8'h00, rxo);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] cmd, input logic [7:0] exp);
        logic [7:0] r;
        cs_low();
        send(cmd, r);
        send(8'h00, r);
        chk(tag, {24'h0, r}, {24'h0, exp});
        cs_high();
    endtask

    // Directed test sequence
    initial begin
        reset     = 1'b1;
        spi_sck   = 1'b0;
        spi_csn   = 1'b1;
        spi_mosi  = 1'b0;
        load_en   = 1'b0;
        load_addr = 7'h00;
        load_data = 8'h00;
        tick(3);
        chk("rst_miso",     {31'h0, spi_miso},    32'h0);
        chk("rst_miso_oe",  {31'h0, spi_miso_oe}, 32'h0);
        chk("rst_wr_valid", {31'h0, wr_valid},    32'h0);
        chk("rst_wr_addr",  {25'h0, wr_addr},     32'h0);
        chk("rst_wr_data",  {24'h0, wr_data},     32'h0);
        chk("rst_busy",     {31'h0, busy},        32'h0);
        reset = 1'b0;
        tick(4);

        // ID read
        w0 = wr_cnt;
        cs_low();
        chk("id_busy",    {31'h0, busy},        32'h1);
        chk("id_oe",      {31'h0, spi_miso_oe}, 32'h1);
        chk("id_miso_cmd",{31'h0, spi_miso},    32'h0);
        send(8'hD0, rx);
        send(8'h00, rx);
        chk("id_value", {24'h0, rx}, 32'h60);
        cs_high();
        chk("id_no_wr",   wr_cnt, w0);
        chk("idle_busy",  {31'h0, busy},        32'h0);
        chk("idle_oe",    {31'h0, spi_miso_oe}, 32'h0);
        chk("idle_miso",  {31'h0, spi_miso},    32'h0);

        // Burst read wrapping 0x7F -> 0x00
        host_load(7'h7E, 8'hA5);
        host_load(7'h7F, 8'h3C);
        cs_low();
        send(8'hFE, rx);
        send(8'h00, rx); chk("burst_7e", {24'h0, rx}, 32'hA5);
        send(8'h00, rx); chk("burst_7f", {24'h0, rx}, 32'h3C);
        send(8'h00, rx); chk("burst_00", {24'h0, rx}, 32'h00);
        cs_high();

        // Two write pairs in one frame
        w0 = wr_cnt;
        cs_low();
        send(8'h74, rx);
        send(8'h27, rx);
        send(8'h75, rx);
        send(8'hA0, rx);
        cs_high();
        chk("pair_cnt",   wr_cnt, w0 + 2);
        chk("pair0_addr", {25'h0, wr_a[w0]},   32'h74);
        chk("pair0_data", {24'h0, wr_d[w0]},   32'h27);
        chk("pair1_addr", {25'h0, wr_a[w0+1]}, 32'h75);
        chk("pair1_data", {24'h0, wr_d[w0+1]}, 32'hA0);
        cs_low();
        send(8'hF4, rx);
        send(8'h00, rx); chk("pair_rd74", {24'h0, rx}, 32'h27);
        send(8'h00, rx); chk("pair_rd75", {24'h0, rx}, 32'hA0);
        cs_high();

        // Partial data byte aborted by csn
        w0 = wr_cnt;
        cs_low();
        send(8'h10, rx);
        spi_xfer(8'hFF, 5, 1'b0, 7'h00, 8'h00, rx);
        cs_high();
        chk("abort_no_wr", wr_cnt, w0);
        rd_chk("abort_reg10", 8'h90, 8'h00);

        // SPI write and host load to the same address in the same clk
        w0 = wr_cnt;
        cs_low();
        send(8'h20, rx);
        spi_xfer(8'h11, 8, 1'b1, 7'h20, 8'h99, rx);
        cs_high();
        chk("coll_cnt",  wr_cnt, w0 + 1);
        chk("coll_data", {24'h0, wr_d[w0]}, 32'h11);
        rd_chk("coll_reg20", 8'hA0, 8'h11);

        // Write attempt to the ID register still strobes but is ignored
        w0 = wr_cnt;
        cs_low();
        send(8'h50, rx);
        send(8'hAB, rx);
        cs_high();
        chk("idwr_cnt",  wr_cnt, w0 + 1);
        chk("idwr_addr", {25'h0, wr_a[w0]}, 32'h50);
        chk("idwr_data", {24'h0, wr_d[w0]}, 32'hAB);
        rd_chk("idwr_keep", 8'hD0, 8'h60);

        // Reset in the middle of a read data byte
        host_load(7'h30, 8'h5A);
        cs_low();
        send(8'hB0, rx);
        spi_xfer(8'h00, 4, 1'b0, 7'h00, 8'h00, rx);
        chk("mid_partial", {24'h0, rx}, 32'h05);
        reset = 1'b1;
        tick(1);
        chk("mid_miso",  {31'h0, spi_miso},    32'h0);
        chk("mid_oe",    {31'h0, spi_miso_oe}, 32'h0);
        chk("mid_busy",  {31'h0, busy},        32'h0);
        chk("mid_wrv",   {31'h0, wr_valid},    32'h0);
        spi_csn = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(4);
        rd_chk("post_reg30", 8'hB0, 8'h00);
        rd_chk("post_reg20", 8'hA0, 8'h00);
        rd_chk("post_reg74", 8'hF4, 8'h00);
        rd_chk("post_reg7e", 8'hFE, 8'h00);
        rd_chk("post_id",    8'hD0, 8'h60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
